ps2_key_decoder: RTL

Receives the raw PS/2 keyboard serial stream and turns it into decoded key events for the game datapath. Main items:
- 2-FF synchroniser and falling-edge detect on the PS/2 lines.
- Start/data/parity/stop frame receiver.
- Scan-code set 2 prefix tracking (E0 extended, F0 break).
- Output is one keycode/make/ext event per key action, with a single-cycle valid strobe.

It sits directly upstream of the datapath and drives its keycode, key_make and key_ext inputs.

---
 rtl/ps2_key_decoder_pkg.sv | 30 +++
 rtl/ps2_key_decoder_if.sv | 20 ++
 rtl/ps2_key_decoder_rx_frame.sv | 141 ++++++++++++++
 rtl/ps2_key_decoder.sv | 107 ++++++++++
 4 files changed

// File: rtl/ps2_key_decoder_pkg.sv
// ps2_key_decoder_pkg
//   Shared constants for the PS/2 keyboard decoder and the game datapath:
//   scan-code set 2 prefix bytes, keyboard control bytes and the game keycodes.
//   No ports; imported with `import ps2_key_decoder_pkg::*;`.
package ps2_key_decoder_pkg;

  typedef logic [7:0] keycode_t;

  // Scan-code set 2 prefixes
  localparam keycode_t PS2_EXT = 8'hE0;
  localparam keycode_t PS2_BRK = 8'hF0;

  // Arrow / game keycodes, shared with the datapath
  localparam keycode_t KEY_LEFT  = 8'h6B;
  localparam keycode_t KEY_RIGHT = 8'h74;
  localparam keycode_t KEY_UP    = 8'h75;
  localparam keycode_t KEY_DOWN  = 8'h72;

  // Keyboard status/control bytes that never describe a key action
  function automatic logic is_ctrl_byte(input keycode_t code);
    logic res;
    case (code)
      8'h00, 8'hAA, 8'hE1, 8'hEE, 8'hFA,
      8'hFC, 8'hFD, 8'hFE, 8'hFF: res = 1'b1;
      default:                    res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/ps2_key_decoder_if.sv
// ps2_key_if
//   Key-event bus from the PS/2 decoder to the game datapath.
//   keycode   : last decoded scan code, prefixes stripped
//   key_make  : 1 = press, 0 = release
//   key_ext   : code was E0-prefixed
//   key_valid : one-cycle strobe, the three fields above just updated
//   frame_err : one-cycle strobe, parity/stop/timeout error
//   master = decoder side (drives), slave = datapath side (observes).
interface ps2_key_if;
  import ps2_key_decoder_pkg::*;

  keycode_t keycode;
  logic     key_make;
  logic     key_ext;
  logic     key_valid;
  logic     frame_err;

  modport master (output keycode, key_make, key_ext, key_valid, frame_err);
  modport slave  (input  keycode, key_make, key_ext, key_valid, frame_err);
endinterface

// File: rtl/ps2_key_decoder_rx_frame.sv
// ps2_rx_frame
//   Synchronises the raw PS/2 lines, detects ps2_clk falling edges and
//   receives start/8 data/odd parity/stop frames, with an inactivity timeout.
//   Ports:
//     clk, reset        : system clock, synchronous active-high reset
//     ps2_clk, ps2_data : raw asynchronous PS/2 lines
//     byte_done         : strobe, good frame received in this (stop-bit fall) cycle
//     rx_byte           : received byte, valid while byte_done is high
//     err               : strobe, parity/stop-bit error or timeout abort
module ps2_rx_frame
  import ps2_key_decoder_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50_000,
  parameter int CNT_W          = 16
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     ps2_clk,
  input  logic     ps2_data,
  output logic     byte_done,
  output keycode_t rx_byte,
  output logic     err
);

  typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_PARITY, ST_STOP} rx_state_t;

  logic             clk_meta_r, clk_sync_r, clk_prev_r;
  logic             data_meta_r, data_sync_r;
  rx_state_t        state_r, state_nxt_s;
  logic [2:0]       bitcnt_r, bitcnt_nxt_s;
  keycode_t         shift_r, shift_nxt_s;
  logic             par_ok_r, par_ok_nxt_s;
  logic [CNT_W-1:0] cnt_r;
  logic             fall_s, timeout_s, done_s, err_s;

  assign fall_s    = clk_prev_r & ~clk_sync_r;
  // A fall in the same cycle keeps the frame alive
  assign timeout_s = (state_r != ST_IDLE) && !fall_s &&
                     (cnt_r == CNT_W'(TIMEOUT_CYCLES - 1));

  // Two-flop synchronisers plus previous-sample flop for edge detect; idle high
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_meta_r  <= 1'b1;
      clk_sync_r  <= 1'b1;
      clk_prev_r  <= 1'b1;
      data_meta_r <= 1'b1;
      data_sync_r <= 1'b1;
    end else begin
      clk_meta_r  <= ps2_clk;
      clk_sync_r  <= clk_meta_r;
      clk_prev_r  <= clk_sync_r;
      data_meta_r <= ps2_data;
      data_sync_r <= data_meta_r;
    end
  end

  // Frame FSM state and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= ST_IDLE;
      bitcnt_r <= 3'd0;
      shift_r  <= 8'h00;
      par_ok_r <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      bitcnt_r <= bitcnt_nxt_s;
      shift_r  <= shift_nxt_s;
      par_ok_r <= par_ok_nxt_s;
    end
  end

  // Inactivity counter: cleared by every edge and while idle
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r <= '0;
    end else if (fall_s || (state_r == ST_IDLE)) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_r + CNT_W'(1);
    end
  end

  // Next-state logic; everything advances only on a ps2_clk fall
  always_comb begin
    state_nxt_s  = state_r;
    bitcnt_nxt_s = bitcnt_r;
    shift_nxt_s  = shift_r;
    par_ok_nxt_s = par_ok_r;
    done_s       = 1'b0;
    err_s        = 1'b0;
    if (timeout_s) begin
      state_nxt_s = ST_IDLE;
      err_s       = 1'b1;
    end else if (fall_s) begin
      case (state_r)
        ST_IDLE: begin
          // A high data bit here is a spurious edge, not a start bit
          if (!data_sync_r) begin
            state_nxt_s  = ST_DATA;
            bitcnt_nxt_s = 3'd0;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_DATA: begin
          // LSB arrives first, so shift in at the top
          shift_nxt_s  = {data_sync_r, shift_r[7:1]};
          bitcnt_nxt_s = bitcnt_r + 3'd1;
          if (bitcnt_r == 3'd7) begin
            state_nxt_s = ST_PARITY;
          end else begin
            state_nxt_s = ST_DATA;
          end
        end
        ST_PARITY: begin
          par_ok_nxt_s = ^{shift_r, data_sync_r};
          state_nxt_s  = ST_STOP;
        end
        ST_STOP: begin
          if (data_sync_r && par_ok_r) begin
            done_s = 1'b1;
          end else begin
            err_s = 1'b1;
          end
          state_nxt_s = ST_IDLE;
        end
        default: begin
          state_nxt_s = ST_IDLE;
        end
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  assign byte_done = done_s;
  assign rx_byte   = shift_r;
  assign err       = err_s;

endmodule

// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder
//   PS/2 keyboard front end: frame receiver plus scan-code set 2 prefix
//   tracking (E0 extended, F0 break). Emits one registered key event per key
//   action with a single-cycle key_valid strobe.
//   Ports:
//     clk, reset        : system clock, synchronous active-high reset
//     ps2_clk, ps2_data : raw asynchronous PS/2 lines (receive only)
//     key_bus           : key event bus (keycode/key_make/key_ext/key_valid/frame_err)
module ps2_key_decoder
  import ps2_key_decoder_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50_000,
  parameter int CNT_W          = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  ps2_key_if.master  key_bus
);

  logic     byte_done_s, rx_err_s;
  keycode_t rx_byte_s;

  keycode_t keycode_r, keycode_nxt_s;
  logic     key_make_r, key_make_nxt_s;
  logic     key_ext_r, key_ext_nxt_s;
  logic     key_valid_r, key_valid_nxt_s;
  logic     frame_err_r;
  logic     ext_pend_r, ext_pend_nxt_s;
  logic     brk_pend_r, brk_pend_nxt_s;

  ps2_rx_frame #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .CNT_W          (CNT_W)
  ) u_rx_frame (
    .clk       (clk),
    .reset     (reset),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .byte_done (byte_done_s),
    .rx_byte   (rx_byte_s),
    .err       (rx_err_s)
  );

  // Prefix tracking and event decode of the byte accepted this cycle
  always_comb begin
    keycode_nxt_s   = keycode_r;
    key_make_nxt_s  = key_make_r;
    key_ext_nxt_s   = key_ext_r;
    key_valid_nxt_s = 1'b0;
    ext_pend_nxt_s  = ext_pend_r;
    brk_pend_nxt_s  = brk_pend_r;
    if (rx_err_s) begin
      // A broken frame invalidates any half-built prefix sequence
      ext_pend_nxt_s = 1'b0;
      brk_pend_nxt_s = 1'b0;
    end else if (byte_done_s) begin
      case (rx_byte_s)
        PS2_EXT: ext_pend_nxt_s = 1'b1;
        PS2_BRK: brk_pend_nxt_s = 1'b1;
        default: begin
          ext_pend_nxt_s = 1'b0;
          brk_pend_nxt_s = 1'b0;
          if (!is_ctrl_byte(rx_byte_s)) begin
            keycode_nxt_s   = rx_byte_s;
            key_ext_nxt_s   = ext_pend_r;
            key_make_nxt_s  = ~brk_pend_r;
            key_valid_nxt_s = 1'b1;
          end else begin
            key_valid_nxt_s = 1'b0;
          end
        end
      endcase
    end else begin
      key_valid_nxt_s = 1'b0;
    end
  end

  // Registered event outputs and pending prefix flags
  always_ff @(posedge clk) begin
    if (reset) begin
      keycode_r   <= 8'h00;
      key_make_r  <= 1'b0;
      key_ext_r   <= 1'b0;
      key_valid_r <= 1'b0;
      frame_err_r <= 1'b0;
      ext_pend_r  <= 1'b0;
      brk_pend_r  <= 1'b0;
    end else begin
      keycode_r   <= keycode_nxt_s;
      key_make_r  <= key_make_nxt_s;
      key_ext_r   <= key_ext_nxt_s;
      key_valid_r <= key_valid_nxt_s;
      frame_err_r <= rx_err_s;
      ext_pend_r  <= ext_pend_nxt_s;
      brk_pend_r  <= brk_pend_nxt_s;
    end
  end

  assign key_bus.keycode   = keycode_r;
  assign key_bus.key_make  = key_make_r;
  assign key_bus.key_ext   = key_ext_r;
  assign key_bus.key_valid = key_valid_r;
  assign key_bus.frame_err = frame_err_r;

endmodule
